dsp_pipelined: RTL

Parametrised DSP slice: the successor to the fixed 4-bit input-registered DSP. It computes an unsigned multiply or add of two operands, with an optional input register bank, 1–4 output pipeline stages, a clock enable and a valid flag carried alongside the data. An optional accumulator is compiled in by macro. It is the primitive the DSP test set uses to exercise pipelined, clock-enabled timing paths.

---
 rtl/dsp_pkg.sv | 17 +
 rtl/dsp_pipe_reg.sv | 22 ++
 rtl/dsp_pipelined.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/dsp_pkg.sv
// Shared definitions for the pipelined DSP slice: operating-mode encodings,
// the pipeline depth limit and the control half of a pipeline stage word.
// A full stage word is {valid, acc, r}. The control part {valid, acc} lives
// here, and each slice appends its own DATA_WIDTH-wide result field.
package dsp_pkg;

    localparam logic DSP_MODE_ADD = 1'b0;
    localparam logic DSP_MODE_MUL = 1'b1;

    localparam int MAX_PIPE_STAGES = 4;

    typedef struct packed {
        logic valid;
        logic acc;
    } dsp_stage_ctrl_t;

endpackage

// File: rtl/dsp_pipe_reg.sv
// Generic register with asynchronous active-high reset and a clock enable.
// It is used for the input bank and for every pipeline stage of the DSP slice.
module dsp_pipe_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ce,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Clear on reset, hold while ce is low, otherwise capture d.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (ce) begin
            q <= d;
        end
    end

endmodule

// File: rtl/dsp_pipelined.sv
// Parametrised DSP slice. It computes an unsigned multiply (m=1) or add (m=0)
// of two half-width operands. The slice has an optional input register bank
// and 1..4 output pipeline stages. A valid flag travels with the data.
// The clock enable freezes every register in the slice.
// Define DSP_PIPELINED_ACCUM_EN to compile in the output accumulator. A valid
// entry with acc=1 then adds its result into out, and acc=0 restarts the sum.
module dsp_pipelined
    import dsp_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int IN_REG      = 1,
    parameter int PIPE_STAGES = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    ce,
    input  logic                    in_valid,
    input  logic [DATA_WIDTH/2-1:0] a,
    input  logic [DATA_WIDTH/2-1:0] b,
    input  logic                    m,
    input  logic                    acc,
    output logic [DATA_WIDTH-1:0]   out,
    output logic                    out_valid
);

    localparam int HALF_WIDTH = DATA_WIDTH / 2;
    localparam int BANK_W     = 2 * HALF_WIDTH + 3;

    typedef struct packed {
        dsp_stage_ctrl_t             ctrl;
        logic [DATA_WIDTH-1:0]       r;
    } stage_t;

    localparam int STAGE_W = $bits(stage_t);

    if (PIPE_STAGES < 1 || PIPE_STAGES > MAX_PIPE_STAGES) begin : g_bad_stages
        $error("dsp_pipelined: PIPE_STAGES must lie in 1..%0d", MAX_PIPE_STAGES);
    end
    if (IN_REG != 0 && IN_REG != 1) begin : g_bad_in_reg
        $error("dsp_pipelined: IN_REG must be 0 or 1");
    end
    if (DATA_WIDTH < 4 || (DATA_WIDTH % 2) != 0) begin : g_bad_width
        $error("dsp_pipelined: DATA_WIDTH must be even and at least 4");
    end

    // Without the accumulator, acc is forced to zero here so that the
    // pipeline never carries it.
    logic acc_used;
`ifdef DSP_PIPELINED_ACCUM_EN
    assign acc_used = acc;
`else
    assign acc_used = 1'b0;
`endif

    logic [BANK_W-1:0]     bank_d;
    logic [BANK_W-1:0]     bank_q;
    logic                  s_valid;
    logic                  s_acc;
    logic                  s_m;
    logic [HALF_WIDTH-1:0] s_a;
    logic [HALF_WIDTH-1:0] s_b;

    assign bank_d = {in_valid, acc_used, m, a, b};

    if (IN_REG == 1) begin : g_in_reg
        dsp_pipe_reg #(.WIDTH(BANK_W)) u_in_reg (
            .clk (clk),
            .rst (rst),
            .ce  (ce),
            .d   (bank_d),
            .q   (bank_q)
        );
    end else begin : g_in_wire
        assign bank_q = bank_d;
    end

    assign {s_valid, s_acc, s_m, s_a, s_b} = bank_q;

    logic [DATA_WIDTH-1:0] a_ext;
    logic [DATA_WIDTH-1:0] b_ext;
    stage_t                arith_stage;

    assign a_ext = {{HALF_WIDTH{1'b0}}, s_a};
    assign b_ext = {{HALF_WIDTH{1'b0}}, s_b};

    // Combinational arithmetic. Both the full product and the carry of the
    // sum fit in DATA_WIDTH, so neither operation can overflow.
    always_comb begin
        arith_stage            = '0;
        arith_stage.ctrl.valid = s_valid;
        arith_stage.ctrl.acc   = s_acc;
        if (s_m == DSP_MODE_MUL) begin
            arith_stage.r = a_ext * b_ext;
        end else begin
            arith_stage.r = a_ext + b_ext;
        end
    end

    stage_t stage_in [PIPE_STAGES];
    stage_t stage_d  [PIPE_STAGES];
    stage_t stage_q  [PIPE_STAGES];
    stage_t last_in;
    stage_t last_q;
    stage_t last_d;

    for (genvar k = 0; k < PIPE_STAGES; k++) begin : g_stage
        if (k == 0) begin : g_first
            assign stage_in[k] = arith_stage;
        end else begin : g_chain
            assign stage_in[k] = stage_q[k-1];
        end

        if (k < PIPE_STAGES - 1) begin : g_mid
            assign stage_d[k] = stage_in[k];
        end else begin : g_last
            assign stage_d[k] = last_d;
        end

        dsp_pipe_reg #(.WIDTH(STAGE_W)) u_stage (
            .clk (clk),
            .rst (rst),
            .ce  (ce),
            .d   (stage_d[k]),
            .q   (stage_q[k])
        );
    end

    assign last_in = stage_in[PIPE_STAGES-1];
    assign last_q  = stage_q[PIPE_STAGES-1];

    // Next value of the output stage. A bubble keeps the previous result and
    // only lets the cleared valid bit through. With the accumulator, acc=1
    // adds the new result into the running value and the sum wraps.
    always_comb begin
        last_d = last_in;
        if (!last_in.ctrl.valid) begin
            last_d.r = last_q.r;
        end
`ifdef DSP_PIPELINED_ACCUM_EN
        else if (last_in.ctrl.acc) begin
            last_d.r = last_q.r + last_in.r;
        end
`endif
    end

    assign out       = last_q.r;
    assign out_valid = last_q.ctrl.valid;

    logic unused_sink;
`ifdef DSP_PIPELINED_ACCUM_EN
    assign unused_sink = last_q.ctrl.acc;
`else
    assign unused_sink = ^{acc, last_q.ctrl.acc};
`endif

endmodule
